data_sram_arbiter: RTL



---
 rtl/data_sram_arbiter_pkg.sv | 29 ++
 rtl/data_sram_arbiter_starve_guard.sv | 53 +++++
 rtl/data_sram_arbiter.sv | 89 ++++++++
 3 files changed

// File: rtl/data_sram_arbiter_pkg.sv
// Shared encodings and payload types for the data SRAM arbiter.
// Build option DATA_SRAM_ARB_STARVE_GUARD_EN selects the DMA starvation guard.
package data_sram_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;
  localparam int unsigned ARB_WEN_W  = 4;
  localparam int unsigned ARB_CNT_W  = 4;

  localparam logic ARB_OWNER_PIPE = 1'b0;
  localparam logic ARB_OWNER_DMA  = 1'b1;

  typedef enum logic {
    ARB_NORMAL    = 1'b0,
    ARB_FORCE_DMA = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [ARB_WEN_W-1:0]  wen;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } arb_req_t;

  // An access with no byte enables is a read.
  function automatic logic arb_is_read(input logic [ARB_WEN_W-1:0] wen);
    return (wen == '0);
  endfunction

endpackage

// File: rtl/data_sram_arbiter_starve_guard.sv
// Starvation guard: counts pipeline wins against a waiting DMA request and
// forces the DMA through once STARVE_LIMIT consecutive wins have been seen.
module arb_starve_guard
  import data_sram_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic dma_req,
  input  logic pipe_gnt,
  input  logic dma_gnt,
  output logic force_dma
);

  localparam logic [ARB_CNT_W-1:0] LIMIT = ARB_CNT_W'(STARVE_LIMIT);

  arb_state_e           state, state_nxt;
  logic [ARB_CNT_W-1:0] starve_cnt, starve_cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB_NORMAL;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // The counter is examined post-update so the DMA wins right after the Nth pipeline win.
  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    if (!dma_req || dma_gnt) begin
      starve_cnt_nxt = '0;
    end else if (pipe_gnt && (starve_cnt != LIMIT)) begin
      starve_cnt_nxt = starve_cnt + ARB_CNT_W'(1);
    end
    case (state)
      ARB_NORMAL: begin
        if (dma_req && (starve_cnt_nxt == LIMIT)) state_nxt = ARB_FORCE_DMA;
      end
      ARB_FORCE_DMA: begin
        if (!dma_req || dma_gnt) state_nxt = ARB_NORMAL;
      end
      default: state_nxt = ARB_NORMAL;
    endcase
  end

  assign force_dma = (state == ARB_FORCE_DMA);

endmodule

// File: rtl/data_sram_arbiter.sv
// Data SRAM port arbiter between the pipeline and the DMA/debug master.
// Define DATA_SRAM_ARB_STARVE_GUARD_EN to bound DMA wait time; otherwise the pipeline always wins.
module data_sram_arbiter
  import data_sram_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_req,
  input  logic [ARB_WEN_W-1:0]  pipe_wen,
  input  logic [ARB_ADDR_W-1:0] pipe_addr,
  input  logic [ARB_DATA_W-1:0] pipe_wdata,
  output logic                  pipe_gnt,
  output logic                  pipe_rvalid,
  output logic [ARB_DATA_W-1:0] pipe_rdata,
  input  logic                  dma_req,
  input  logic [ARB_WEN_W-1:0]  dma_wen,
  input  logic [ARB_ADDR_W-1:0] dma_addr,
  input  logic [ARB_DATA_W-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [ARB_DATA_W-1:0] dma_rdata,
  output logic                  data_sram_en,
  output logic [ARB_WEN_W-1:0]  data_sram_wen,
  output logic [ARB_ADDR_W-1:0] data_sram_addr,
  output logic [ARB_DATA_W-1:0] data_sram_wdata,
  input  logic [ARB_DATA_W-1:0] data_sram_rdata
);

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
    $error("data_sram_arbiter: STARVE_LIMIT must be in 1..15");
  end

  logic     force_dma;
  logic     granted;
  arb_req_t pipe_pl, dma_pl, sel_pl;
  logic     resp_valid;
  logic     resp_owner;

`ifdef DATA_SRAM_ARB_STARVE_GUARD_EN
  arb_starve_guard #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_guard (
    .clk      (clk),
    .reset    (reset),
    .dma_req  (dma_req),
    .pipe_gnt (pipe_gnt),
    .dma_gnt  (dma_gnt),
    .force_dma(force_dma)
  );
`else
  assign force_dma = 1'b0;
`endif

  // Grants are same-cycle; both are held low while reset is asserted.
  assign pipe_gnt = ~reset & pipe_req & ~(force_dma & dma_req);
  assign dma_gnt  = ~reset & dma_req & (force_dma | ~pipe_req);
  assign granted  = pipe_gnt | dma_gnt;

  assign pipe_pl = '{wen: pipe_wen, addr: pipe_addr, wdata: pipe_wdata};
  assign dma_pl  = '{wen: dma_wen,  addr: dma_addr,  wdata: dma_wdata};

  always_comb begin
    sel_pl          = pipe_pl;
    if (dma_gnt) sel_pl = dma_pl;
    data_sram_en    = granted;
    data_sram_wen   = granted ? sel_pl.wen : '0;
    data_sram_addr  = sel_pl.addr;
    data_sram_wdata = sel_pl.wdata;
  end

  // Remember who issued the read so next cycle's data is steered back to them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_owner <= ARB_OWNER_PIPE;
    end else begin
      resp_valid <= granted & arb_is_read(sel_pl.wen);
      resp_owner <= dma_gnt ? ARB_OWNER_DMA : ARB_OWNER_PIPE;
    end
  end

  assign pipe_rvalid = ~reset & resp_valid & (resp_owner == ARB_OWNER_PIPE);
  assign dma_rvalid  = ~reset & resp_valid & (resp_owner == ARB_OWNER_DMA);
  assign pipe_rdata  = data_sram_rdata;
  assign dma_rdata   = data_sram_rdata;

endmodule
